priority_arbiter_8: RTL and testbench



---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_pick.sv | 32 +++
 rtl/priority_arbiter_8.sv | 116 +++++++++++
 tb/tb_priority_arbiter_8.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way priority arbiter.
// Optional round-robin fairness is enabled by defining ARB_ROUND_ROBIN_EN.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int ARB_N        = 8;
  localparam int ARB_MAX_HOLD = 16;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: starts at 'start' and walks downward with
// wrap-around, returning the first set request.
module arb_pick
  import arb_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          any
);

  function automatic logic [IW-1:0] wrap_sub(input logic [IW-1:0] s, input int k);
    int c;
    c = int'(s) - k;
    if (c < 0) c = c + N;
    return IW'(c);
  endfunction

  assign any = |req;

  // Loop from the lowest priority upward so the highest-priority hit is the last write.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[wrap_sub(start, i)]) idx = wrap_sub(start, i);
    end
  end

endmodule

// File: rtl/priority_arbiter_8.sv
// Grant-locking 8-way arbiter with hold timeout and a dead cycle between grants.
// Define ARB_ROUND_ROBIN_EN to rotate the search start after each grant.
module priority_arbiter_8
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IW       = $clog2(N),
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid,
  output logic          timeout
);

  localparam int CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arb_state_t    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  logic [IW-1:0] pick_start;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          rel_normal;
  logic          hold_hit;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] last_q, last_d;

  assign pick_start = (last_q == '0) ? IW'(N - 1) : last_q - 1'b1;
`else
  assign pick_start = IW'(N - 1);
`endif

  arb_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .start (pick_start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign rel_normal = done || !req[gnt_idx_q] || !en;
  assign hold_hit   = (MAX_HOLD != 0) && (hold_cnt_q == CW'(HOLD_LAST));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      GRANT: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (rel_normal || hold_hit) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          timeout_d = hold_hit && !rel_normal;
        end
      end
      // IDLE and the single RELEASE cycle arbitrate identically.
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        if (en && pick_any) begin
          state_d    = GRANT;
          gnt_d      = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          gnt_idx_d  = pick_idx;
          hold_cnt_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d     = pick_idx;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_priority_arbiter_8.sv
// Directed scoreboard bench for priority_arbiter_8 (MAX_HOLD=16).
module tb_priority_arbiter_8;

  typedef struct {
    string      tag;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  priority_arbiter_8 #(.N(8), .IW(3), .MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExp(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                         input logic et);
    exp_t e;
    e.tag = tag;
    e.gnt = eg;
    e.idx = ei;
    e.to  = et;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    total++;
    assert (sb.size() > 0)
    else begin
      bad++;
      $error("[TB] FAIL scoreboard: observed=empty expected=entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      assert (gnt === e.gnt)
      else begin
        bad++;
        $error("[TB] FAIL %s gnt: observed=%h expected=%h", e.tag, gnt, e.gnt);
      end
      total++;
      assert (gnt_idx === e.idx)
      else begin
        bad++;
        $error("[TB] FAIL %s gnt_idx: observed=%0d expected=%0d", e.tag, gnt_idx, e.idx);
      end
      total++;
      assert (gnt_valid === (e.gnt != 8'h00))
      else begin
        bad++;
        $error("[TB] FAIL %s gnt_valid: observed=%b expected=%b", e.tag, gnt_valid,
               (e.gnt != 8'h00));
      end
      total++;
      assert (timeout === e.to)
      else begin
        bad++;
        $error("[TB] FAIL %s timeout: observed=%b expected=%b", e.tag, timeout, e.to);
      end
    end
  endtask

  // Drive inputs, record what must appear after the next rising edge, then check it.
  task automatic applyStimulus(input logic e_in, input logic [7:0] r_in, input logic d_in,
                               input string tag, input logic [7:0] eg, input logic [2:0] ei,
                               input logic et);
    en   = e_in;
    req  = r_in;
    done = d_in;
    pushExp(tag, eg, ei, et);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pushExp("reset", 8'h00, 3'd0, 1'b0);
    checkOutput();
    rst_n = 1'b1;
  endtask

  initial begin
    doReset();

    // Reset asserted in the middle of a grant takes effect without a clock edge.
    applyStimulus(1'b1, 8'h08, 1'b0, "grant3", 8'h08, 3'd3, 1'b0);
    applyStimulus(1'b1, 8'h08, 1'b0, "hold3", 8'h08, 3'd3, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    pushExp("async_rst", 8'h00, 3'd0, 1'b0);
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h08, 1'b0, "regrant3", 8'h08, 3'd3, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, "drop3", 8'h00, 3'd3, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, "idle3", 8'h00, 3'd3, 1'b0);

    // Priority between requesters 7 and 0, starting from a fresh pointer.
    doReset();
    applyStimulus(1'b1, 8'h81, 1'b0, "prio_first", 8'h80, 3'd7, 1'b0);
    applyStimulus(1'b1, 8'h81, 1'b1, "prio_done", 8'h00, 3'd7, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
    applyStimulus(1'b1, 8'h81, 1'b0, "prio_second", 8'h01, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, "prio_drop", 8'h00, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, "prio_idle", 8'h00, 3'd0, 1'b0);
`else
    applyStimulus(1'b1, 8'h81, 1'b0, "prio_second", 8'h80, 3'd7, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, "prio_drop", 8'h00, 3'd7, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, "prio_idle", 8'h00, 3'd7, 1'b0);
`endif

    // Hold timeout: grant visible for exactly 16 cycles, then a timeout pulse.
    applyStimulus(1'b1, 8'h10, 1'b0, "to_grant", 8'h10, 3'd4, 1'b0);
    for (int i = 0; i < 15; i++)
      applyStimulus(1'b1, 8'h10, 1'b0, "to_hold", 8'h10, 3'd4, 1'b0);
    applyStimulus(1'b1, 8'h10, 1'b0, "to_pulse", 8'h00, 3'd4, 1'b1);
    applyStimulus(1'b1, 8'h10, 1'b0, "to_regrant", 8'h10, 3'd4, 1'b0);

    // done in the final hold cycle turns the exit into a normal release.
    for (int i = 0; i < 15; i++)
      applyStimulus(1'b1, 8'h10, 1'b0, "coll_hold", 8'h10, 3'd4, 1'b0);
    applyStimulus(1'b1, 8'h10, 1'b1, "coll_done", 8'h00, 3'd4, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, "coll_idle", 8'h00, 3'd4, 1'b0);

    // Disable during a grant forces release and blocks new grants.
`ifdef ARB_ROUND_ROBIN_EN
    applyStimulus(1'b1, 8'hFF, 1'b0, "dis_grant", 8'h08, 3'd3, 1'b0);
    applyStimulus(1'b0, 8'hFF, 1'b0, "dis_release", 8'h00, 3'd3, 1'b0);
    applyStimulus(1'b0, 8'hFF, 1'b0, "dis_idle", 8'h00, 3'd3, 1'b0);
    applyStimulus(1'b0, 8'hFF, 1'b1, "dis_stay", 8'h00, 3'd3, 1'b0);
`else
    applyStimulus(1'b1, 8'hFF, 1'b0, "dis_grant", 8'h80, 3'd7, 1'b0);
    applyStimulus(1'b0, 8'hFF, 1'b0, "dis_release", 8'h00, 3'd7, 1'b0);
    applyStimulus(1'b0, 8'hFF, 1'b0, "dis_idle", 8'h00, 3'd7, 1'b0);
    applyStimulus(1'b0, 8'hFF, 1'b1, "dis_stay", 8'h00, 3'd7, 1'b0);
`endif

    // Request drop hands over to requester 1 after one dead cycle.
    applyStimulus(1'b1, 8'h20, 1'b0, "drop_grant5", 8'h20, 3'd5, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, "drop_hold5", 8'h20, 3'd5, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, "drop_dead", 8'h00, 3'd5, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, "drop_grant1", 8'h02, 3'd1, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b1, "low_done", 8'h00, 3'd1, 1'b0);
    applyStimulus(1'b1, 8'h06, 1'b0, "low_grant2", 8'h04, 3'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
